// File: rtl/blink_code_sched_if.sv
// Requester-side code push channel for blink_code_sched.
// The master presents a blink code; the scheduler (slave) accepts it when code_ready is high.
interface blink_code_sched_if #(
    parameter int unsigned CODE_WIDTH = 4
) ();
    logic                  code_valid;
    logic [CODE_WIDTH-1:0] code_data;
    logic                  code_ready;

    modport master (
        output code_valid,
        output code_data,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code_data,
        output code_ready
    );
endinterface

// File: rtl/blink_code_sched.sv
// Status LED scheduler: plays queued blink codes as pulse trains, otherwise mirrors a heartbeat.
// Optional BLINK_CODE_SCHED_DROP_EN: never backpressure, drop pushes while full and count them.
module blink_code_sched #(
    parameter int unsigned PULSE_LEN_COUNT = 32'h007F_27C2,
    parameter int unsigned INTER_CODE_GAP  = 32'h01FC_9F08,
    parameter int unsigned CODE_WIDTH      = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hb_in,
    blink_code_sched_if.slave           req,
    output logic                        led_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 codes_done
`ifdef BLINK_CODE_SCHED_DROP_EN
    ,
    output logic [31:0]                 codes_dropped
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [31:0]   PULSE_LAST = 32'(PULSE_LEN_COUNT - 1);
    localparam logic [31:0]   GAP_LAST   = 32'(INTER_CODE_GAP - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [31:0]           pulse_cnt, pulse_nxt;
    logic [CODE_WIDTH-1:0] rem_cnt, rem_nxt;
    logic                  led_nxt;
    logic                  done_inc;

    logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [CODE_WIDTH-1:0] head;

    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);
    assign head       = mem[rd_ptr];

    // Acceptance is judged on pre-pop occupancy, so a full FIFO never takes a code on its pop cycle.
`ifdef BLINK_CODE_SCHED_DROP_EN
    logic drop;
    assign req.code_ready = 1'b1;
    assign push           = req.code_valid && !fifo_full;
    assign drop           = req.code_valid && fifo_full;
`else
    assign req.code_ready = !fifo_full;
    assign push           = req.code_valid && req.code_ready;
`endif

    // Code storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req.code_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

`ifdef BLINK_CODE_SCHED_DROP_EN
    // Saturating count of pushes refused because the FIFO was full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            codes_dropped <= '0;
        end else if (drop && (codes_dropped != 32'hFFFF_FFFF)) begin
            codes_dropped <= codes_dropped + 32'd1;
        end
    end
`endif

    // Next state; led_nxt is the LED level for the cycle spent in state_nxt.
    always_comb begin
        state_nxt = state;
        pulse_nxt = pulse_cnt;
        rem_nxt   = rem_cnt;
        led_nxt   = 1'b0;
        pop       = 1'b0;
        done_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                led_nxt = hb_in;
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // A zero code carries no pulses and is discarded without leaving IDLE.
                    if (head != '0) begin
                        state_nxt = S_ON;
                        rem_nxt   = head;
                        pulse_nxt = '0;
                        led_nxt   = 1'b1;
                    end
                end
            end
            S_ON: begin
                led_nxt = 1'b1;
                if (pulse_cnt == PULSE_LAST) begin
                    pulse_nxt = '0;
                    led_nxt   = 1'b0;
                    if (rem_cnt > CODE_WIDTH'(1)) begin
                        rem_nxt   = rem_cnt - CODE_WIDTH'(1);
                        state_nxt = S_OFF;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else begin
                    pulse_nxt = pulse_cnt + 32'd1;
                end
            end
            S_OFF: begin
                if (pulse_cnt == PULSE_LAST) begin
                    pulse_nxt = '0;
                    led_nxt   = 1'b1;
                    state_nxt = S_ON;
                end else begin
                    pulse_nxt = pulse_cnt + 32'd1;
                end
            end
            S_GAP: begin
                if (pulse_cnt == GAP_LAST) begin
                    pulse_nxt = '0;
                    led_nxt   = hb_in;
                    done_inc  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    pulse_nxt = pulse_cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pulse_nxt = '0;
                rem_nxt   = '0;
                led_nxt   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pulse_cnt  <= '0;
            rem_cnt    <= '0;
            led_out    <= 1'b0;
            busy       <= 1'b0;
            codes_done <= '0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_nxt;
            rem_cnt   <= rem_nxt;
            led_out   <= led_nxt;
            busy      <= (state_nxt != S_IDLE);
            if (done_inc) begin
                codes_done <= codes_done + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_blink_code_sched.sv
// Randomized self-checking bench for blink_code_sched against a pulse-schedule reference model.
// Build with +define+BLINK_CODE_SCHED_DROP_EN to exercise the drop-on-full variant.
module tb_blink_code_sched;

    localparam int unsigned PLC   = 4;
    localparam int unsigned GAP   = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hb_in;
    logic        led_out;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [31:0] codes_done;
`ifdef BLINK_CODE_SCHED_DROP_EN
    logic [31:0] codes_dropped;
`endif

    blink_code_sched_if #(.CODE_WIDTH(CW)) bus ();

    blink_code_sched #(
        .PULSE_LEN_COUNT(PLC),
        .INTER_CODE_GAP (GAP),
        .CODE_WIDTH     (CW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hb_in        (hb_in),
        .req          (bus.slave),
        .led_out      (led_out),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .codes_done   (codes_done)
`ifdef BLINK_CODE_SCHED_DROP_EN
        ,
        .codes_dropped(codes_dropped)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued codes plus the LED levels still owed for the code being played.
    int          m_q[$];
    bit          m_sched[$];
    bit          m_busy;
    bit          m_led;
    logic [31:0] m_done;
    logic [31:0] m_drop;
    int          send_q[$];

    function automatic bit m_ready();
`ifdef BLINK_CODE_SCHED_DROP_EN
        return 1'b1;
`else
        return (m_q.size() < DEPTH);
`endif
    endfunction

    function automatic logic [69:0] exp_vec();
        return {m_led, m_busy, 3'(m_q.size()), m_ready(), m_done, m_drop};
    endfunction

    function automatic logic [69:0] obs_vec();
        logic [31:0] d;
`ifdef BLINK_CODE_SCHED_DROP_EN
        d = codes_dropped;
`else
        d = 32'd0;
`endif
        return {led_out, busy, fifo_level, bus.code_ready, codes_done, d};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sched.delete();
        send_q.delete();
        m_busy          = 1'b0;
        m_led           = 1'b0;
        m_done          = 32'd0;
        m_drop          = 32'd0;
        bus.code_valid  = 1'b0;
        bus.code_data   = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step(output bit acc);
        bit full;
        int c;
        full = (m_q.size() >= DEPTH);
        acc  = bus.code_valid && m_ready();
        if (!m_busy && m_q.size() > 0) begin
            c = m_q.pop_front();
            if (c != 0) begin
                for (int p = 1; p <= c; p++) begin
                    repeat (PLC) m_sched.push_back(1'b1);
                    if (p < c) repeat (PLC) m_sched.push_back(1'b0);
                end
                repeat (GAP) m_sched.push_back(1'b0);
            end
        end
        if (acc) begin
            if (!full) m_q.push_back(int'(bus.code_data));
            else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
        end
        if (m_sched.size() > 0) begin
            m_led  = m_sched.pop_front();
            m_busy = 1'b1;
        end else begin
            m_led = hb_in;
            if (m_busy) m_done = m_done + 32'd1;
            m_busy = 1'b0;
        end
    endtask

    // One clock: model update, edge, then the requester presents its next code.
    task automatic step();
        bit acc;
        model_step(acc);
        @(posedge clk);
        #1;
        if (acc) bus.code_valid = 1'b0;
        if (!bus.code_valid && send_q.size() > 0) begin
            bus.code_valid = 1'b1;
            bus.code_data  = CW'(send_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        hb_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [69:0] want;
        rst            = 1'b0;
        hb_in          = 1'b1;
        bus.code_valid = 1'b0;
        bus.code_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        want = {1'b0, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0};
        n_checks++;
        if (obs_vec() !== want) $display("FAIL reset_values: got %h want %h", obs_vec(), want);
        else n_pass++;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_idle_passthrough();
        logic prev_hb;
        do_reset();
        prev_hb = hb_in;
        for (int i = 0; i < 20; i++) begin
            hb_in = 1'($urandom);
            prev_hb = hb_in;
            step();
            n_checks++;
            if (led_out !== prev_hb || busy !== 1'b0)
                $display("FAIL idle_passthrough cyc %0d: led=%b busy=%b want led=%b busy=0", i, led_out, busy, prev_hb);
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL idle_model cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_single_code();
        logic [27:0] pat;
        int nb;
        do_reset();
        send_q.push_back(3);
        pat = '0;
        nb  = 0;
        for (int i = 0; i < 40; i++) begin
            hb_in = 1'($urandom);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL single_code cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (busy) begin
                pat = {pat[26:0], led_out};
                nb++;
            end
        end
        n_checks++;
        if (nb !== 28) $display("FAIL single_busy_len: got %0d want 28", nb);
        else n_pass++;
        n_checks++;
        if (pat !== 28'hF0F_0F00) $display("FAIL single_pattern: got %h want %h", pat, 28'hF0F_0F00);
        else n_pass++;
        n_checks++;
        if (codes_done !== 32'd1) $display("FAIL single_done: got %0d want 1", codes_done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        send_q.push_back(2);
        for (int k = 0; k < 5; k++) send_q.push_back(int'($urandom_range(1, 3)));
        for (int i = 0; i < 6; i++) begin
            hb_in = 1'($urandom);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL backpressure_fill cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (fifo_level !== 3'd4 || bus.code_ready !== 1'b0)
            $display("FAIL backpressure_full: level=%0d ready=%b want level=4 ready=0", fifo_level, bus.code_ready);
        else n_pass++;
        cyc = 0;
        while ((send_q.size() > 0 || bus.code_valid || m_q.size() > 0 || m_busy) && cyc < 400) begin
            hb_in = 1'($urandom);
            step();
            cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL backpressure_play cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (cyc >= 400 || codes_done !== 32'd6)
            $display("FAIL backpressure_done: codes_done=%0d cycles=%0d want 6 within 400", codes_done, cyc);
        else n_pass++;
    endtask

    task automatic test_zero_code();
        int hi;
        do_reset();
        send_q.push_back(0);
        send_q.push_back(1);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            hb_in = 1'b0;
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL zero_code cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (busy && led_out) hi++;
        end
        n_checks++;
        if (hi !== 4 || codes_done !== 32'd1)
            $display("FAIL zero_code_result: high=%0d done=%0d want high=4 done=1", hi, codes_done);
        else n_pass++;
    endtask

    task automatic test_random();
        int cyc;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0 && send_q.size() < 3)
                send_q.push_back(int'($urandom_range(0, 5)));
            hb_in = 1'($urandom);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        cyc = 0;
        while ((send_q.size() > 0 || bus.code_valid || m_q.size() > 0 || m_busy) && cyc < 2000) begin
            hb_in = 1'($urandom);
            step();
            cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_drain cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (cyc >= 2000 || busy !== 1'b0) $display("FAIL random_drain_timeout: cycles=%0d busy=%b want idle", cyc, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_code();
        logic [69:0] want;
        logic prev_hb;
        int cyc;
        do_reset();
        send_q.push_back(5);
        send_q.push_back(2);
        send_q.push_back(3);
        cyc = 0;
        while (!m_busy && cyc < 20) begin
            hb_in = 1'($urandom);
            step();
            cyc++;
        end
        repeat (8) begin
            hb_in = 1'($urandom);
            step();
        end
        n_checks++;
        if (led_out !== 1'b1 || busy !== 1'b1 || fifo_level !== 3'd2)
            $display("FAIL midcode_second_pulse: led=%b busy=%b level=%0d want 1 1 2", led_out, busy, fifo_level);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        want = {1'b0, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0};
        n_checks++;
        if (obs_vec() !== want) $display("FAIL midcode_reset: got %h want %h", obs_vec(), want);
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hb_in = 1'($urandom);
            prev_hb = hb_in;
            step();
            n_checks++;
            if (led_out !== prev_hb || obs_vec() !== exp_vec())
                $display("FAIL midcode_resume cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

`ifdef BLINK_CODE_SCHED_DROP_EN
    task automatic test_drop();
        int cyc;
        do_reset();
        send_q = {2, 1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 9; i++) begin
            hb_in = 1'($urandom);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL drop_fill cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (codes_dropped !== 32'd2 || fifo_level !== 3'd4 || bus.code_ready !== 1'b1)
            $display("FAIL drop_count: dropped=%0d level=%0d ready=%b want 2 4 1", codes_dropped, fifo_level, bus.code_ready);
        else n_pass++;
        cyc = 0;
        while ((m_q.size() > 0 || m_busy) && cyc < 400) begin
            hb_in = 1'($urandom);
            step();
            cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL drop_play cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (cyc >= 400 || codes_done !== 32'd5)
            $display("FAIL drop_done: codes_done=%0d cycles=%0d want 5 within 400", codes_done, cyc);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_passthrough();
        test_single_code();
        test_backpressure();
        test_zero_code();
        test_random();
        test_reset_mid_code();
`ifdef BLINK_CODE_SCHED_DROP_EN
        test_drop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
